// File: rtl/pcie_app_pkg.sv
// pcie_app_pkg: shared PCIe application types, TX arbiter state encoding and defaults.
package pcie_app_pkg;
  typedef struct packed {
    logic        sop;
    logic        eop;
    logic        valid;
    logic [1:0]  empty;
    logic        err;
    logic [31:0] parity;
  } tx_st_avalon_type;

  typedef enum logic [1:0] {IDLE_ST, GNT_ST, XFER_ST, RELEASE_ST} tx_arb_state_e;

  localparam int TX_ARB_TIMEOUT_DEF = 1024;

  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tx_st_arbiter_if.sv
// tx_st_arbiter_if: requester-side and HIP-side Avalon-ST TX signals seen by the arbiter.
interface tx_st_arbiter_if import pcie_app_pkg::*; #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]                iREQ;
  logic [NUM_REQ-1:0]                oGNT;
  tx_st_avalon_type [NUM_REQ-1:0]    iTX_ST;
  logic [NUM_REQ-1:0][255:0]         iTX_ST_DATA;
  logic                              iTX_ST_READY;
  tx_st_avalon_type                  oTX_ST;
  logic [255:0]                      oTX_ST_DATA;
  logic                              oARB_TIMEOUT_PULSE;
  logic                              oBUSY;

  modport master (
    output iREQ, iTX_ST, iTX_ST_DATA, iTX_ST_READY,
    input  oGNT, oTX_ST, oTX_ST_DATA, oARB_TIMEOUT_PULSE, oBUSY
  );

  modport slave (
    input  iREQ, iTX_ST, iTX_ST_DATA, iTX_ST_READY,
    output oGNT, oTX_ST, oTX_ST_DATA, oARB_TIMEOUT_PULSE, oBUSY
  );
endinterface

// File: rtl/tx_rr_pick.sv
// tx_rr_pick: combinational round-robin pick; ptr is the highest-priority index.
module tx_rr_pick import pcie_app_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx
);
  // Scan from the lowest-priority offset down so the closest requester to ptr wins last.
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int c;
      c = int'(ptr) + i;
      c = c >= NUM_REQ ? c - NUM_REQ : c;
      if (req[c[IW-1:0]]) idx = c[IW-1:0];
    end
    onehot = |req ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/tx_st_arbiter.sv
// tx_st_arbiter: round-robin arbiter muxing NUM_REQ Avalon-ST TX requesters onto the HIP,
// with a per-grant idle watchdog that revokes stalled grants.
module tx_st_arbiter import pcie_app_pkg::*; #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = TX_ARB_TIMEOUT_DEF
) (
  input  logic            iCLK,
  input  logic            iRST,
  tx_st_arbiter_if.slave  bus
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  tx_arb_state_e     state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, pick_oh;
  logic [IW-1:0]     idx_q, idx_d, rr_q, rr_d, pick_idx;
  logic [WW-1:0]     wd_q, wd_d;
  logic              timeout, active;
  tx_st_avalon_type  g;

  tx_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req(bus.iREQ), .ptr(rr_q), .onehot(pick_oh), .idx(pick_idx)
  );

  assign g      = bus.iTX_ST[idx_q];
  assign active = state_q == GNT_ST || state_q == XFER_ST;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= IDLE_ST;
      gnt_q   <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    timeout = 1'b0;
    case (state_q)
      IDLE_ST: if (|bus.iREQ && bus.iTX_ST_READY) begin
        state_d = GNT_ST;
        gnt_d   = pick_oh;
        idx_d   = pick_idx;
        wd_d    = '0;
      end
      GNT_ST, XFER_ST: begin
        wd_d = g.valid ? '0 : wd_q + 1'b1;
        if (state_q == GNT_ST && g.valid && g.sop) state_d = g.eop ? RELEASE_ST : XFER_ST;
        else if (state_q == XFER_ST && g.valid && g.eop) state_d = RELEASE_ST;
        else if (state_q == GNT_ST && !bus.iREQ[idx_q]) state_d = RELEASE_ST;
        else if (!g.valid && wd_q == WW'(TIMEOUT_CYC)) begin
          state_d = RELEASE_ST;
          timeout = 1'b1;
        end
        gnt_d = state_d == RELEASE_ST ? '0 : gnt_q;
      end
      RELEASE_ST: begin
        state_d = IDLE_ST;
        rr_d    = int'(idx_q) + 1 >= NUM_REQ ? '0 : idx_q + 1'b1;
      end
      default: state_d = IDLE_ST;
    endcase
  end

  // Non-granted requesters never reach the HIP: only the winner is muxed, and
  // framing bits are squashed whenever no grant is live.
  always_comb begin
    bus.oTX_ST       = g;
    bus.oTX_ST.valid = g.valid && active;
    bus.oTX_ST.sop   = g.sop && active;
    bus.oTX_ST.eop   = g.eop && active;
    bus.oTX_ST_DATA  = |gnt_q ? bus.iTX_ST_DATA[idx_q] : '0;
  end

  assign bus.oGNT               = gnt_q;
  assign bus.oBUSY              = state_q != IDLE_ST;
  assign bus.oARB_TIMEOUT_PULSE = timeout;
endmodule

// File: tb/tb_tx_st_arbiter.sv
// tb_tx_st_arbiter: directed checks of grant order, muxing, watchdog, ready gating and reset.
module tb_tx_st_arbiter;
  import pcie_app_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  tx_st_arbiter_if #(.NUM_REQ(4)) bus ();

  tx_st_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(1024)) dut (
    .iCLK(clk), .iRST(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic tx_st_avalon_type mk(input logic s, input logic e, input logic v);
    tx_st_avalon_type t;
    t = '0;
    t.sop = s;
    t.eop = e;
    t.valid = v;
    return t;
  endfunction

  task automatic idle_all();
    bus.iREQ = '0;
    for (int i = 0; i < 4; i++) begin
      bus.iTX_ST[i] = '0;
      bus.iTX_ST_DATA[i] = '0;
    end
  endtask

  initial begin
    idle_all();
    bus.iTX_ST_READY = 1'b1;
    tick();
    tick();
    chk("rst_gnt", bus.oGNT, 0);
    chk("rst_busy", bus.oBUSY, 0);
    chk("rst_pulse", bus.oARB_TIMEOUT_PULSE, 0);
    chk("rst_valid", bus.oTX_ST.valid, 0);
    rst = 1'b0;

    // single-beat TLP from requester 0
    bus.iREQ = 4'b0001;
    tick();
    chk("t1_gnt", bus.oGNT, 4'b0001);
    chk("t1_busy", bus.oBUSY, 1);
    bus.iTX_ST[0] = mk(1, 1, 1);
    bus.iTX_ST_DATA[0] = 256'hA5A5;
    #1;
    chk("t1_valid", bus.oTX_ST.valid, 1);
    chk("t1_sopeop", {bus.oTX_ST.sop, bus.oTX_ST.eop}, 2'b11);
    chk("t1_data", bus.oTX_ST_DATA, 256'hA5A5);
    tick();
    chk("t1_gnt_drop", bus.oGNT, 0);
    chk("t1_valid_squash", bus.oTX_ST.valid, 0);
    chk("t1_rel_busy", bus.oBUSY, 1);
    idle_all();
    tick();
    chk("t1_idle_busy", bus.oBUSY, 0);

    // all four requesting: order 0,1,2,3,0 after a reset brings rr_ptr to 0
    rst = 1'b1;
    #2;
    rst = 1'b0;
    bus.iREQ = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % 4;
      tick();
      chk($sformatf("rr%0d_gnt_a", k), bus.oGNT, 4'b0001 << e);
      tick();
      chk($sformatf("rr%0d_gnt_b", k), bus.oGNT, 4'b0001 << e);
      bus.iTX_ST[e] = mk(1, 1, 1);
      tick();
      chk($sformatf("rr%0d_rel", k), bus.oGNT, 0);
      bus.iTX_ST[e] = '0;
      tick();
    end
    idle_all();
    tick();

    // requester 2 sends 3 beats while requester 1 drives valid without a grant
    bus.iREQ = 4'b0100;
    tick();
    chk("t3_gnt", bus.oGNT, 4'b0100);
    bus.iTX_ST[1] = mk(1, 1, 1);
    bus.iTX_ST_DATA[1] = 256'hBAD;
    bus.iTX_ST[2] = mk(1, 0, 1);
    bus.iTX_ST_DATA[2] = 256'hD0;
    #1;
    chk("t3_d0", bus.oTX_ST_DATA, 256'hD0);
    chk("t3_d0_eop", bus.oTX_ST.eop, 0);
    tick();
    bus.iTX_ST[2] = mk(0, 0, 1);
    bus.iTX_ST_DATA[2] = 256'hD1;
    #1;
    chk("t3_d1", bus.oTX_ST_DATA, 256'hD1);
    chk("t3_d1_sop", bus.oTX_ST.sop, 0);
    tick();
    bus.iTX_ST[2] = mk(0, 1, 1);
    bus.iTX_ST_DATA[2] = 256'hD2;
    #1;
    chk("t3_d2", bus.oTX_ST_DATA, 256'hD2);
    chk("t3_d2_eop", bus.oTX_ST.eop, 1);
    tick();
    chk("t3_rel_gnt", bus.oGNT, 0);
    chk("t3_rel_valid", bus.oTX_ST.valid, 0);
    chk("t3_rel_data", bus.oTX_ST_DATA, 0);
    bus.iREQ = '0;
    bus.iTX_ST[2] = '0;
    tick();
    chk("t3_idle_valid", bus.oTX_ST.valid, 0);
    idle_all();

    // ready low blocks a grant; REQ drop before sop releases without a pulse
    bus.iTX_ST_READY = 1'b0;
    bus.iREQ = 4'b0001;
    repeat (3) tick();
    chk("t4_no_gnt", bus.oGNT, 0);
    bus.iTX_ST_READY = 1'b1;
    tick();
    chk("t4_gnt", bus.oGNT, 4'b0001);
    bus.iREQ = '0;
    #1;
    chk("t4_drop_pulse", bus.oARB_TIMEOUT_PULSE, 0);
    tick();
    chk("t4_drop_gnt", bus.oGNT, 0);
    tick();

    // watchdog: requester 1 granted but never sends
    bus.iREQ = 4'b0010;
    tick();
    chk("t5_gnt", bus.oGNT, 4'b0010);
    repeat (1023) tick();
    chk("t5_pre_pulse", bus.oARB_TIMEOUT_PULSE, 0);
    tick();
    chk("t5_pulse", bus.oARB_TIMEOUT_PULSE, 1);
    chk("t5_pulse_gnt", bus.oGNT, 4'b0010);
    tick();
    chk("t5_after_pulse", bus.oARB_TIMEOUT_PULSE, 0);
    chk("t5_after_gnt", bus.oGNT, 0);
    bus.iREQ = '0;
    tick();

    // reset mid-packet; rr_ptr=2 here so requester 3 wins first
    bus.iREQ = 4'b1001;
    tick();
    chk("t6_gnt", bus.oGNT, 4'b1000);
    bus.iTX_ST[3] = mk(1, 0, 1);
    tick();
    bus.iTX_ST[3] = mk(0, 0, 1);
    #1;
    chk("t6_xfer_valid", bus.oTX_ST.valid, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_gnt", bus.oGNT, 0);
    chk("t6_rst_valid", bus.oTX_ST.valid, 0);
    chk("t6_rst_busy", bus.oBUSY, 0);
    #1;
    rst = 1'b0;
    bus.iTX_ST[3] = '0;
    tick();
    chk("t6_resume_gnt", bus.oGNT, 4'b0001);
    idle_all();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tx_st_arbiter.md
TX_ST_ARBITER -- requirements
Module: tx_st_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of TX requesters; index 0 is the MM completion engine.
REQ-002 Parameter TIMEOUT_CYC, default 1024: maximum number of idle cycles allowed in a grant before the arbiter revokes it.
REQ-003 iCLK  in  1  clock shared with the PCIE HIP Avalon-ST TX interface.
REQ-004 iRST  in  1  asynchronous active-high reset.
REQ-005 iREQ  in  NUM_REQ  per-requester TX request; held high by the requester until its TLP is sent.
REQ-006 oGNT  out  NUM_REQ  one-hot grant, registered.
REQ-007 iTX_ST  in  NUM_REQ x pcie_app_pkg::tx_st_avalon_type  per-requester sop/eop/valid/empty/err/parity.
REQ-008 iTX_ST_DATA  in  NUM_REQ x 256  per-requester TLP data.
REQ-009 iTX_ST_READY  in  1  HIP tx_st_ready.
REQ-010 oTX_ST  out  tx_st_avalon_type  muxed to the HIP.
REQ-011 oTX_ST_DATA  out  256  muxed to the HIP.
REQ-012 oARB_TIMEOUT_PULSE  out  1  one-cycle pulse when a grant is revoked by timeout.
REQ-013 oBUSY  out  1  high in any state except IDLE_ST.

Function
REQ-014 The FSM states SHALL be IDLE_ST, GNT_ST, XFER_ST and RELEASE_ST.
REQ-015 IDLE_ST: when |iREQ and iTX_ST_READY, the arbiter SHALL select a winner round-robin from rr_ptr, register oGNT one-hot, and go to GNT_ST on the next edge; otherwise it stays in IDLE_ST.
REQ-016 Round-robin rule: rr_ptr marks the highest-priority index, and the search proceeds rr_ptr, rr_ptr+1 ... modulo NUM_REQ.
REQ-017 On leaving RELEASE_ST, rr_ptr SHALL become (winner+1) mod NUM_REQ.
REQ-018 GNT_ST: a granted valid&sop&eop SHALL go to RELEASE_ST; valid&sop without eop SHALL go to XFER_ST.
REQ-019 XFER_ST: a granted valid&eop SHALL go to RELEASE_ST.
REQ-020 RELEASE_ST: oGNT SHALL be all-zero and the FSM SHALL return to IDLE_ST after exactly 1 cycle.
REQ-021 Release latency: grant-drop SHALL follow the eop beat by 1 cycle, which satisfies a requester that waits for !GNT before deasserting REQ.
REQ-022 oTX_ST/oTX_ST_DATA SHALL be a zero-latency combinational mux of the winner's inputs.
REQ-023 oTX_ST.valid, sop and eop SHALL be forced to 0 outside GNT_ST/XFER_ST.
REQ-024 When oGNT is zero, oTX_ST_DATA SHALL be 0.
REQ-025 valid asserted by a non-granted requester SHALL be ignored and SHALL not reach the HIP.
REQ-026 A watchdog counter, ceil(log2(TIMEOUT_CYC+1)) bits, SHALL clear on grant and on every granted valid beat and increment otherwise in GNT_ST/XFER_ST.
REQ-027 When the watchdog counter reaches TIMEOUT_CYC, the arbiter SHALL pulse oARB_TIMEOUT_PULSE for 1 cycle and go to RELEASE_ST.
REQ-028 The arbiter SHALL not check iTX_ST_READY mid-packet; honouring ready latency is the granted requester's duty. Ready is sampled only for a new grant.
REQ-029 A REQ that drops while granted before sop SHALL cause the FSM to go to RELEASE_ST with no pulse.
REQ-030 A single requester requesting continuously SHALL be re-granted at most every 3 cycles (IDLE, GNT, RELEASE minimum).
REQ-031 Simultaneous REQ rise on several indices in IDLE_ST SHALL grant exactly one index per REQ-016.

Reset
REQ-032 Assertion of iRST SHALL immediately force state=IDLE_ST, oGNT=0, rr_ptr=0, watchdog=0, oARB_TIMEOUT_PULSE=0, oBUSY=0, and oTX_ST.valid/sop/eop=0.
REQ-033 Reset mid-packet SHALL abandon the packet with no eop generated.
REQ-034 Arbitration SHALL resume on the first edge after iRST falls.

Structure
REQ-035 tx_st_avalon_type SHALL remain in pcie_app_pkg.
REQ-036 A new typedef tx_arb_state_e and the constant TX_ARB_TIMEOUT_DEF=1024 SHALL be added to pcie_app_pkg.
REQ-037 The round-robin selection SHALL be a sub-module tx_rr_pick (combinational: inputs req and ptr; output one-hot winner plus index).
REQ-038 The FSM, mux and watchdog SHALL reside in tx_st_arbiter.

Verification
REQ-039 Test: REQ[0] only, single-beat TLP -> oGNT=4'b0001 1 cycle after REQ; sop/eop/valid visible on oTX_ST the same cycle as the requester drives them; GNT low the following cycle.
REQ-040 Test: REQ=4'b1111 held, 1-beat TLPs -> grant order 0,1,2,3,0; each grant lasts 2 cycles.
REQ-041 Test: requester 2 sends a 3-beat TLP while requester 1 asserts valid -> only requester 2's data is seen on the HIP; requester 1's valid is never forwarded.
REQ-042 Test: grant with no sop for 1024 cycles -> oARB_TIMEOUT_PULSE high for 1 cycle at watchdog=1024; oGNT=0 the next cycle.
REQ-043 Test: iTX_ST_READY=0 with REQ pending -> no grant; ready rises -> oGNT set 1 cycle later.
REQ-044 Test: iRST asserted during XFER_ST -> oGNT=0 and valid=0 asynchronously; after reset, rr_ptr=0 so index 0 wins.
